spike_rate_decoder: RTL and testbench
=====================================

// Module: spike_rate_decoder
// PURPOSE
// - Rate decoder for the LIF spike path: the inverse of the neuron's current->spike encoding.
// - Counts spikes on one neuron's spike line over a programmable window of cycles.
// - Presents each window's count as a registered value with a valid/ready handshake.
// - Sits after a lif instance; its output feeds the 7-seg/uo_out path or the STDP weight logic.
// PARAMETERS
// - WIN_W  8  width of win_len and of the internal window-cycle counter
// - CNT_W  8  width of the spike count / rate_out (saturating)
// - ISI_W  8  width of the inter-spike-interval counter / isi_out (ISI_MEASURE_EN only)
// PORTS
// - clk         in   1      clock; all state changes on its rising edge
// - rst         in   1      asynchronous, active-high reset
// - en          in   1      decode enable; low = idle, partial window discarded
// - spike_in    in   1      spike line; each cycle it is high counts as one spike
// - win_len     in   WIN_W  window length in cycles, sampled at each window start; 0 is treated as 1
// - rate_out    out  CNT_W  spike count of the last completed window
// - rate_valid  out  1      rate_out holds an unconsumed result
// - rate_ready  in   1      consumer accepts rate_out when rate_valid && rate_ready
// - rate_sat    out  1      the window in rate_out saturated at 2^CNT_W-1
// - overrun     out  1      one-cycle pulse: an unconsumed result was overwritten
// - isi_out     out  ISI_W  last inter-spike interval in cycles
// - isi_valid   out  1      one-cycle pulse when isi_out updates
// BEHAVIOUR
// - Reset: FSM=IDLE; all counters, rate_out, rate_sat, isi_out = 0; rate_valid, overwrun/overrun, isi_valid = 0.
// - FSM states: IDLE, COUNT. IDLE->COUNT on the first cycle en=1 (win_len latched). COUNT->IDLE whenever en=0.
// - Window: cycle counter runs 0..L-1 in COUNT (L = latched win_len, 0->1); spike_in sampled every COUNT cycle,
//   including the first and last. Count saturates at 2^CNT_W-1 and sets the internal sat bit.
// - Window end (counter == L-1): rate_out <= count, including a spike on that cycle; rate_sat <= sat;
//   rate_valid <= 1 the following cycle. Counters clear, win_len re-sampled: back-to-back windows, no gap cycle.
// - Latency: en high at cycle 0 -> first window covers cycles 0..L-1 -> rate_valid=1 at cycle L.
// - Handshake: rate_valid stays high, rate_out stable, until a cycle with rate_ready=1. After that cycle
//   rate_valid=0 unless a new result loads in the same cycle.
// - New result while rate_valid && !rate_ready: overwrite rate_out/rate_sat, overrun pulses 1 cycle, rate_valid stays 1.
// - New result and rate_ready in the same cycle: old value consumed, new value loaded, rate_valid stays 1, no overrun.
// - en low mid-window: partial count discarded, no result. The pending rate_out/rate_valid is kept and still handshakes.
// - Async rst mid-window: immediate return to reset values; no partial result is ever emitted.
// CONFIGURATION
// - ISI_MEASURE_EN defined:
//   - The ISI counter runs in COUNT and saturates at 2^ISI_W-1.
//   - On a spike, isi_out <= cycles since the previous spike, isi_valid pulses, and the counter restarts.
//   - The first spike after entering COUNT only arms the counter and produces no isi_valid.
// - ISI_MEASURE_EN undefined: no ISI logic; isi_out is tied to 0 and isi_valid to 0. Ports are present in both builds.
// STRUCTURE
// - Package snn_pkg: dec_state_t enum {IDLE, COUNT}, default width localparams, a sat_max(width) helper constant.
// - Sub-module sat_counter (parameter W; ports clr, inc, q, sat). Instantiated for the spike count and for the ISI count.
// - The window counter is plain wrap logic in this module.
// TESTING
// - win_len=10, spike_in high every 2nd cycle starting at cycle 0, rate_ready=1
//   -> rate_out=5, rate_valid at cycle 10, 20, ... with no gap.
// - CNT_W=4, win_len=20, spike_in held 1 -> rate_out=15, rate_sat=1. Next window with no spikes -> rate_out=0, rate_sat=0.
// - win_len=4, rate_ready=0 across two window ends -> overrun pulse at the 2nd end, rate_out = 2nd count.
//   Then ready=1 for 1 cycle -> rate_valid drops.
// - en dropped at window cycle 6 of 10, raised 3 cycles later -> no result from the aborted window.
//   Next valid arrives 10 cycles after the re-enable.
// - ISI_MEASURE_EN build, spikes at cycles 3, 8, 15 -> no isi_valid at 3; isi_out=5 at 8; isi_out=7 at 15.
// - rst pulsed mid-window with rate_valid=1 -> all outputs 0 in the same cycle. Fresh window starts on rst release with en=1.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types and constants for the spike-path decoders.
// Provides the decoder state enum, default widths and the saturation ceiling helper.
package snn_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } dec_state_t;

    localparam int DEF_WIN_W = 8;
    localparam int DEF_CNT_W = 8;
    localparam int DEF_ISI_W = 8;

    // Largest value an unsigned counter of the given width can hold.
    function automatic logic [31:0] sat_max(input int width);
        if (width >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: clear has priority over increment, the count sticks at all-ones.
// sat flags that the counter is at its ceiling and will not advance further.
module sat_counter
    import snn_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         sat
);

    localparam logic [W-1:0] MAX = W'(sat_max(W));

    assign sat = (q == MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && !sat) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Windowed spike-rate decoder with valid/ready result handshake.
// Optional inter-spike-interval measurement is built when ISI_MEASURE_EN is defined.
module spike_rate_decoder
    import snn_pkg::*;
#(
    parameter int WIN_W = DEF_WIN_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int ISI_W = DEF_ISI_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             spike_in,
    input  logic [WIN_W-1:0] win_len,
    output logic [CNT_W-1:0] rate_out,
    output logic             rate_valid,
    input  logic             rate_ready,
    output logic             rate_sat,
    output logic             overrun,
    output logic [ISI_W-1:0] isi_out,
    output logic             isi_valid
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

    dec_state_t state_reg, state_next;

    logic [WIN_W-1:0] win_cnt_reg;
    logic [WIN_W-1:0] len_reg;
    logic [WIN_W-1:0] cur_len;
    logic [WIN_W-1:0] last_idx;
    logic             win_start;
    logic             win_end;

    logic             cnt_clr;
    logic             cnt_inc;
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_sat;
    logic [CNT_W-1:0] cnt_final;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (en)  state_next = COUNT;
            COUNT:   if (!en) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The first cycle of every window (including the IDLE->COUNT cycle) uses win_len live,
    // so back-to-back windows pick up a new length with no gap cycle.
    assign win_start = (state_reg == IDLE) || (win_cnt_reg == '0);
    assign cur_len   = win_start ? win_len : len_reg;
    assign last_idx  = (cur_len == '0) ? '0 : cur_len - 1'b1;
    assign win_end   = en && (win_cnt_reg == last_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt_reg <= '0;
            len_reg     <= '0;
        end else begin
            if (!en || win_end) begin
                win_cnt_reg <= '0;
            end else begin
                win_cnt_reg <= win_cnt_reg + 1'b1;
            end
            if (en && win_start) begin
                len_reg <= win_len;
            end
        end
    end

    assign cnt_clr = !en || win_end;
    assign cnt_inc = en && spike_in;

    sat_counter #(.W(CNT_W)) u_spike_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (cnt_inc),
        .q   (cnt_q),
        .sat (cnt_sat)
    );

    // A spike on the closing cycle of the window still belongs to that window.
    assign cnt_final = (spike_in && !cnt_sat) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rate_out   <= '0;
            rate_sat   <= 1'b0;
            rate_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= win_end && rate_valid && !rate_ready;
            if (win_end) begin
                rate_out   <= cnt_final;
                rate_sat   <= (cnt_final == CNT_MAX);
                rate_valid <= 1'b1;
            end else if (rate_ready) begin
                rate_valid <= 1'b0;
            end
        end
    end

`ifdef ISI_MEASURE_EN
    logic             armed_reg;
    logic             isi_clr;
    logic             isi_inc;
    logic [ISI_W-1:0] isi_q;
    logic             isi_sat;
    logic [ISI_W-1:0] isi_final;
    logic             isi_hit;

    // The counter holds cycles elapsed since the last spike minus one; the spike cycle adds the last.
    assign isi_clr   = !en || spike_in;
    assign isi_inc   = en && armed_reg;
    assign isi_final = isi_sat ? isi_q : isi_q + 1'b1;
    assign isi_hit   = en && spike_in && armed_reg;

    sat_counter #(.W(ISI_W)) u_isi_cnt (
        .clk (clk),
        .rst (rst),
        .clr (isi_clr),
        .inc (isi_inc),
        .q   (isi_q),
        .sat (isi_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed_reg <= 1'b0;
            isi_out   <= '0;
            isi_valid <= 1'b0;
        end else begin
            armed_reg <= en && (armed_reg || spike_in);
            isi_valid <= isi_hit;
            if (isi_hit) begin
                isi_out <= isi_final;
            end
        end
    end
`else
    assign isi_out   = '0;
    assign isi_valid = 1'b0;
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Scoreboard bench for spike_rate_decoder (CNT_W=4); ISI expectations apply when ISI_MEASURE_EN is defined.
module tb_spike_rate_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       spike_in;
    logic [7:0] win_len;
    logic [3:0] rate_out;
    logic       rate_valid;
    logic       rate_ready;
    logic       rate_sat;
    logic       overrun;
    logic [7:0] isi_out;
    logic       isi_valid;

    typedef struct {
        int cnt;
        int sat;
        int cyc;
    } rate_exp_t;

    typedef struct {
        int val;
        int cyc;
    } isi_exp_t;

    rate_exp_t rate_q[$];
    isi_exp_t  isi_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    spike_rate_decoder #(
        .WIN_W (8),
        .CNT_W (4),
        .ISI_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .spike_in   (spike_in),
        .win_len    (win_len),
        .rate_out   (rate_out),
        .rate_valid (rate_valid),
        .rate_ready (rate_ready),
        .rate_sat   (rate_sat),
        .overrun    (overrun),
        .isi_out    (isi_out),
        .isi_valid  (isi_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic pat(input int kind, input int i);
        case (kind)
            0:       return (i % 2) == 0;
            1:       return i < 20;
            2:       return (i % 3) == 0;
            default: return 1'b0;
        endcase
    endfunction

    // Drives ncyc cycles of enabled input and queues one expected result per completed window.
    task automatic run_win(input int len, input int ncyc, input int kind);
        int st;
        int c;
        int eff;
        rate_exp_t e;
        eff     = (len == 0) ? 1 : len;
        st      = cyc;
        c       = 0;
        en      = 1'b1;
        win_len = 8'(len);
        for (int i = 0; i < ncyc; i++) begin
            spike_in = pat(kind, i);
            c += int'(spike_in);
            if ((i % eff) == eff - 1) begin
                e.cnt = (c > 15) ? 15 : c;
                e.sat = (c >= 15) ? 1 : 0;
                e.cyc = st + i + 1;
                rate_q.push_back(e);
                c = 0;
            end
            step();
        end
    endtask

    always @(negedge clk) begin : monitor
        rate_exp_t e;
        isi_exp_t  ie;
        if (!rst && rate_valid && rate_ready) begin
            $display("rate cycle=%0d out=%0d sat=%0d", cyc, rate_out, rate_sat);
            if (rate_q.size() == 0) begin
                check("rate_unexpected", 1, 0);
            end else begin
                e = rate_q.pop_front();
                check("rate_out", int'(rate_out), e.cnt);
                check("rate_sat", int'(rate_sat), e.sat);
                check("rate_cycle", cyc, e.cyc);
            end
        end
        if (!rst && isi_valid) begin
            $display("isi cycle=%0d out=%0d", cyc, isi_out);
            if (isi_q.size() == 0) begin
                check("isi_unexpected", 1, 0);
            end else begin
                ie = isi_q.pop_front();
                check("isi_out", int'(isi_out), ie.val);
                check("isi_cycle", cyc, ie.cyc);
            end
        end
    end

    initial begin
        int        st;
        rate_exp_t e;
        isi_exp_t  ie;

        rst        = 1'b1;
        en         = 1'b0;
        spike_in   = 1'b0;
        win_len    = 8'd0;
        rate_ready = 1'b0;
        repeat (2) step();
        check("reset_outputs", int'({rate_out, rate_sat, rate_valid, overrun, isi_out, isi_valid}), 0);
        rst = 1'b0;
        step();

        // win_len=0 behaves as single-cycle windows
        rate_ready = 1'b1;
        run_win(0, 3, 0);
        en = 1'b0; spike_in = 1'b0;
        repeat (2) step();

        // Alternating spikes, 10-cycle windows, back to back
        run_win(10, 30, 0);
        en = 1'b0; spike_in = 1'b0;
        repeat (2) step();

        // Saturating window followed by an empty window
        run_win(20, 40, 1);
        en = 1'b0; spike_in = 1'b0;
        repeat (2) step();

        // Abort at window cycle 6, re-enable three cycles later
        win_len = 8'd10;
        en      = 1'b1;
        for (int i = 0; i < 6; i++) begin
            spike_in = 1'b1;
            step();
        end
        en = 1'b0; spike_in = 1'b0;
        repeat (3) step();
        run_win(10, 10, 2);
        en = 1'b0; spike_in = 1'b0;
        repeat (2) step();

        // Two results with no consumer: overrun on the second
        rate_ready = 1'b0;
        win_len    = 8'd4;
        en         = 1'b1;
        st         = cyc;
        for (int i = 0; i < 8; i++) begin
            spike_in = (i < 3) || (i == 4);
            step();
            if (i == 3) begin
                check("ovr_first_valid", int'(rate_valid), 1);
                check("ovr_first_out", int'(rate_out), 3);
                check("ovr_first_pulse", int'(overrun), 0);
            end
        end
        check("ovr_second_pulse", int'(overrun), 1);
        check("ovr_second_out", int'(rate_out), 1);
        check("ovr_second_valid", int'(rate_valid), 1);
        e.cnt = 1; e.sat = 0; e.cyc = st + 8;
        rate_q.push_back(e);
        rate_ready = 1'b1; en = 1'b0; spike_in = 1'b0;
        step();
        rate_ready = 1'b0;
        check("ovr_valid_dropped", int'(rate_valid), 0);
        check("ovr_pulse_one_cycle", int'(overrun), 0);
        repeat (2) step();

        // Asynchronous reset while a result is pending, fresh window on release
        win_len  = 8'd4;
        en       = 1'b1;
        spike_in = 1'b1;
        repeat (6) step();
        check("rst_pre_valid", int'(rate_valid), 1);
        rst = 1'b1;
        #1;
        check("rst_async_outputs", int'({rate_out, rate_sat, rate_valid, overrun, isi_out, isi_valid}), 0);
        step();
        rst        = 1'b0;
        rate_ready = 1'b1;
        st         = cyc;
        e.cnt = 4; e.sat = 0; e.cyc = st + 4;
        rate_q.push_back(e);
        repeat (4) step();
        en = 1'b0; spike_in = 1'b0;
        repeat (2) step();

        // Spikes at window cycles 3, 8, 15
        win_len = 8'd50;
        en      = 1'b1;
        st      = cyc;
`ifdef ISI_MEASURE_EN
        ie.val = 5; ie.cyc = st + 9;
        isi_q.push_back(ie);
        ie.val = 7; ie.cyc = st + 16;
        isi_q.push_back(ie);
`endif
        for (int i = 0; i < 20; i++) begin
            spike_in = (i == 3) || (i == 8) || (i == 15);
            step();
        end
`ifdef ISI_MEASURE_EN
        check("isi_last_value", int'(isi_out), 7);
`else
        check("isi_tied_zero", int'(isi_out), 0);
`endif
        en = 1'b0; spike_in = 1'b0;
        repeat (3) step();

        check("rate_queue_drained", rate_q.size(), 0);
        check("isi_queue_drained", isi_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
